// File: rtl/dbg_trace_buf.sv
// dbg_trace_buf: multi-lane commit trace compactor feeding a DEPTH-entry FIFO
// drained one record per cycle over valid/ready.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   cm_* (NCH lanes)     retirement records from the commit stage, lane i at [W*i +: W]
//   stall_req            core must hold off commits (near full or halted)
//   out_valid/out_ready  head-record handshake
//   out_*                head record fields (zero while empty)
//   halted               a halting (ebreak/invalid) record has been enqueued
//   level                occupied entries
//   drop_cnt             records lost to overflow, saturating
module dbg_trace_buf #(
    parameter int NCH         = 2,
    parameter int DEPTH       = 16,
    parameter int STOP_ON_BRK = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           cm_valid,
    input  logic [32*NCH-1:0]        cm_pc,
    input  logic [32*NCH-1:0]        cm_inst,
    input  logic [NCH-1:0]           cm_brk,
    input  logic [NCH-1:0]           cm_ivd,
    input  logic [NCH-1:0]           cm_gpr_wen,
    input  logic [5*NCH-1:0]         cm_gpr_waddr,
    input  logic [32*NCH-1:0]        cm_gpr_wdata,
    output logic                     stall_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_gpr_wdata,
    output logic [4:0]               out_gpr_waddr,
    output logic                     out_gpr_wen,
    output logic [1:0]               out_kind,
    output logic [15:0]              out_seq,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 120;

    logic [RW-1:0] mem_q [DEPTH];
    logic [RW-1:0] mem_d [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]   seq_q, seq_d, drop_cnt_q, drop_cnt_d;
    logic          halted_q, halted_d;
    logic [NCH-1:0] acc;
    logic [AW:0]   n, free;
    logic [AW-1:0] slot;
    logic [15:0]   sq;
    logic [16:0]   dsum;
    logic          stop, push, pop;

    assign level     = wr_ptr_q - rd_ptr_q;
    assign out_valid = wr_ptr_q != rd_ptr_q;
    assign halted    = halted_q;
    assign drop_cnt  = drop_cnt_q;
    assign stall_req = (level > (AW+1)'(DEPTH - NCH)) || halted_q;
    // Gate the head so an empty FIFO presents all-zero fields.
    assign {out_pc, out_inst, out_kind, out_gpr_wen, out_gpr_waddr, out_gpr_wdata, out_seq} =
        out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    always_comb begin
        acc  = halted_q ? '0 : cm_valid;
        stop = 1'b0;
        // Keep lanes up to and including the first halting lane; later lanes vanish uncounted.
        if (STOP_ON_BRK != 0) begin
            for (int i = 0; i < NCH; i++) begin
                if (stop) acc[i] = 1'b0;
                if (acc[i] && (cm_brk[i] || cm_ivd[i])) stop = 1'b1;
            end
        end
        n = '0;
        for (int i = 0; i < NCH; i++) n = n + (AW+1)'(acc[i]);
        // Credit is taken from the start-of-cycle level; a same-cycle pop does not help.
        free       = (AW+1)'(DEPTH) - level;
        push       = (n != '0) && (n <= free);
        pop        = out_valid && out_ready;
        mem_d      = mem_q;
        wr_ptr_d   = push ? wr_ptr_q + n : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        seq_d      = push ? seq_q + 16'(n) : seq_q;
        halted_d   = halted_q || (push && |(acc & (cm_brk | cm_ivd)));
        dsum       = {1'b0, drop_cnt_q} + 17'(n);
        drop_cnt_d = (!push && n != '0) ? (dsum[16] ? 16'hFFFF : dsum[15:0]) : drop_cnt_q;
        slot       = wr_ptr_q[AW-1:0];
        sq         = seq_q;
        for (int i = 0; i < NCH; i++) begin
            if (push && acc[i]) begin
                mem_d[slot] = {cm_pc[32*i +: 32], cm_inst[32*i +: 32],
                               cm_ivd[i] ? 2'd2 : {1'b0, cm_brk[i]},
                               cm_gpr_wen[i], cm_gpr_waddr[5*i +: 5],
                               cm_gpr_wdata[32*i +: 32], sq};
                slot = slot + AW'(1);
                sq   = sq + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            seq_q      <= '0;
            drop_cnt_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            seq_q      <= seq_d;
            drop_cnt_q <= drop_cnt_d;
            halted_q   <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_dbg_trace_buf.sv
// tb_dbg_trace_buf: directed self-checking bench for dbg_trace_buf (NCH=2, DEPTH=16).
module tb_dbg_trace_buf;
    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  cm_valid, cm_brk, cm_ivd, cm_gpr_wen;
    logic [63:0] cm_pc, cm_inst, cm_gpr_wdata;
    logic [9:0]  cm_gpr_waddr;
    logic        stall_req, out_valid, out_ready, out_gpr_wen, halted;
    logic [31:0] out_pc, out_inst, out_gpr_wdata;
    logic [4:0]  out_gpr_waddr, level;
    logic [1:0]  out_kind;
    logic [15:0] out_seq, drop_cnt;
    int checks = 0, errors = 0;

    dbg_trace_buf #(.NCH(2), .DEPTH(16), .STOP_ON_BRK(1)) dut (
        .clk(clk), .reset(reset), .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_inst(cm_inst),
        .cm_brk(cm_brk), .cm_ivd(cm_ivd), .cm_gpr_wen(cm_gpr_wen), .cm_gpr_waddr(cm_gpr_waddr),
        .cm_gpr_wdata(cm_gpr_wdata), .stall_req(stall_req), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_gpr_wdata(out_gpr_wdata),
        .out_gpr_waddr(out_gpr_waddr), .out_gpr_wen(out_gpr_wen), .out_kind(out_kind),
        .out_seq(out_seq), .halted(halted), .level(level), .drop_cnt(drop_cnt));

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cm_valid = '0; cm_brk = '0; cm_ivd = '0; cm_gpr_wen = '0;
        cm_pc = '0; cm_inst = '0; cm_gpr_wdata = '0; cm_gpr_waddr = '0;
    endtask

    task automatic lane(input int l, input logic [31:0] pc, input logic brk, input logic ivd);
        cm_valid[l] = 1'b1; cm_brk[l] = brk; cm_ivd[l] = ivd; cm_gpr_wen[l] = 1'b1;
        cm_pc[32*l +: 32] = pc; cm_inst[32*l +: 32] = pc ^ 32'h5A5A5A5A;
        cm_gpr_wdata[32*l +: 32] = pc + 32'd1; cm_gpr_waddr[5*l +: 5] = 5'(l + 1);
    endtask

    task automatic do_reset();
        idle();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
    endtask

    task automatic fill(input int cnt);
        for (int k = 0; k < cnt / 2; k++) begin
            idle(); lane(0, 32'h1000 + 32'(k), 0, 0); lane(1, 32'h2000 + 32'(k), 0, 0); cyc();
        end
        if (cnt % 2 == 1) begin idle(); lane(0, 32'h3000, 0, 0); cyc(); end
        idle();
    endtask

    task automatic test_reset();
        out_ready = 1'b0; idle();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (halted !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL reset_halt got %b%b exp 00", halted, stall_req); end
        checks++; if (drop_cnt !== 16'd0 || out_pc !== 32'd0 || out_seq !== 16'd0) begin errors++; $display("FAIL reset_fields got %h %h %h exp 0", drop_cnt, out_pc, out_seq); end
        cyc(); cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        idle();
        cm_valid = 2'b01; cm_pc[31:0] = 32'h80000000; cm_inst[31:0] = 32'h00100093;
        cm_gpr_wen = 2'b01; cm_gpr_waddr[4:0] = 5'd1; cm_gpr_wdata[31:0] = 32'd1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_comb got %b exp 0", out_valid); end
        cyc(); idle();
        checks++; if (out_valid !== 1'b1 || level !== 5'd1) begin errors++; $display("FAIL single_vl got %b %0d exp 1 1", out_valid, level); end
        checks++; if (out_pc !== 32'h80000000 || out_inst !== 32'h00100093) begin errors++; $display("FAIL single_pc got %h %h exp 80000000 00100093", out_pc, out_inst); end
        checks++; if (out_kind !== 2'd0 || out_gpr_wen !== 1'b1 || out_gpr_waddr !== 5'd1 || out_gpr_wdata !== 32'd1 || out_seq !== 16'd0)
            begin errors++; $display("FAIL single_rec got %0d %b %0d %h %0d exp 0 1 1 1 0", out_kind, out_gpr_wen, out_gpr_waddr, out_gpr_wdata, out_seq); end
        cyc();
        checks++; if (out_pc !== 32'h80000000 || level !== 5'd1) begin errors++; $display("FAIL single_hold got %h %0d exp 80000000 1", out_pc, level); end
        out_ready = 1'b1; cyc(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL single_pop got %b %0d exp 0 0", out_valid, level); end
    endtask

    task automatic test_compaction();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hA1; exp_pc[1] = 32'hB0; exp_pc[2] = 32'hB1;
        do_reset();
        lane(1, 32'hA1, 0, 0); cyc();
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL comp_l1 got %0d exp 1", level); end
        idle(); lane(0, 32'hB0, 0, 0); lane(1, 32'hB1, 0, 0); cyc(); idle();
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL comp_l3 got %0d exp 3", level); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_pc !== exp_pc[k] || out_seq !== 16'(k)) begin errors++; $display("FAIL comp_order%0d got %h %0d exp %h %0d", k, out_pc, out_seq, exp_pc[k], k); end
            cyc();
        end
        out_ready = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL comp_drain got %0d exp 0", level); end
    endtask

    task automatic test_overflow();
        do_reset(); out_ready = 1'b0;
        fill(14);
        checks++; if (level !== 5'd14 || stall_req !== 1'b0) begin errors++; $display("FAIL ovf_14 got %0d %b exp 14 0", level, stall_req); end
        fill(1);
        checks++; if (level !== 5'd15 || stall_req !== 1'b1) begin errors++; $display("FAIL ovf_15 got %0d %b exp 15 1", level, stall_req); end
        lane(0, 32'hDEAD, 0, 0); lane(1, 32'hBEEF, 0, 0); cyc(); idle();
        checks++; if (drop_cnt !== 16'd2 || level !== 5'd15) begin errors++; $display("FAIL ovf_drop got %0d %0d exp 2 15", drop_cnt, level); end
        fill(1);
        checks++; if (level !== 5'd16 || drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_full got %0d %0d exp 16 2", level, drop_cnt); end
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            checks++; if (out_seq !== 16'(k)) begin errors++; $display("FAIL ovf_seq%0d got %0d exp %0d", k, out_seq, k); end
            cyc();
        end
        out_ready = 1'b0;
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf_drain got %0d exp 0", level); end
    endtask

    task automatic test_halt();
        do_reset(); out_ready = 1'b0;
        lane(0, 32'hC0, 1, 0); lane(1, 32'hC1, 0, 0); cyc(); idle();
        checks++; if (level !== 5'd1 || halted !== 1'b1 || stall_req !== 1'b1) begin errors++; $display("FAIL halt_set got %0d %b %b exp 1 1 1", level, halted, stall_req); end
        checks++; if (out_kind !== 2'd1 || out_pc !== 32'hC0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL halt_rec got %0d %h %0d exp 1 c0 0", out_kind, out_pc, drop_cnt); end
        lane(0, 32'hD0, 0, 0); lane(1, 32'hD1, 0, 0); cyc();
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL halt_ignore got %0d exp 1", level); end
        out_ready = 1'b1; cyc(); cyc(); out_ready = 1'b0; idle();
        checks++; if (level !== 5'd0 || halted !== 1'b1) begin errors++; $display("FAIL halt_pop got %0d %b exp 0 1", level, halted); end
        do_reset();
        lane(1, 32'hE1, 1, 1); cyc(); idle();
        checks++; if (out_kind !== 2'd2 || out_pc !== 32'hE1 || halted !== 1'b1) begin errors++; $display("FAIL halt_ivd got %0d %h %b exp 2 e1 1", out_kind, out_pc, halted); end
        do_reset();
        fill(16);
        lane(0, 32'hF0, 1, 0); cyc(); idle();
        checks++; if (halted !== 1'b0 || drop_cnt !== 16'd1 || level !== 5'd16) begin errors++; $display("FAIL halt_ovf got %b %0d %0d exp 0 1 16", halted, drop_cnt, level); end
    endtask

    task automatic test_back_to_back();
        do_reset(); out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            idle(); lane(0, 32'(k), 0, 0); cyc();
            checks++; if (out_seq !== 16'(k) || out_pc !== 32'(k) || level !== 5'd1) begin errors++; $display("FAIL b2b%0d got %0d %h %0d exp %0d %h 1", k, out_seq, out_pc, level, k, k); end
        end
        idle(); cyc(); out_ready = 1'b0;
        checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0d %b exp 0 0", level, out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset(); out_ready = 1'b0;
        fill(5);
        checks++; if (level !== 5'd5) begin errors++; $display("FAIL ares_fill got %0d exp 5", level); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 5'd0 || halted !== 1'b0) begin errors++; $display("FAIL ares_now got %b %0d %b exp 0 0 0", out_valid, level, halted); end
        reset = 1'b0;
        lane(0, 32'h77, 0, 0); cyc(); idle();
        checks++; if (out_seq !== 16'd0 || level !== 5'd1 || out_pc !== 32'h77) begin errors++; $display("FAIL ares_seq got %0d %0d %h exp 0 1 77", out_seq, level, out_pc); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_compaction();
        test_overflow();
        test_halt();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
